argmax_topk_scan: RTL and testbench

Runtime-configurable arg-max/arg-min scanner for the classifier output stage. It reads up to N scores from the single-port Y RAM and reports the winning index and value. It also reports the runner-up value and the best-to-second margin, so the anomaly logic can flag low-confidence decisions. It replaces the fixed-length, max-only scanner and adds runtime length, compare modes, a busy/done handshake and confidence scoring.

---
 rtl/argmax_topk_scan.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_argmax_topk_scan.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_topk_scan.sv
// argmax_topk_scan: runtime-length arg-max / arg-min scanner over the Y RAM.
// Reports the winning index and score, and optionally the runner-up score,
// the best-to-second margin and a low-confidence flag.
// Build option: define ARGMAX_MARGIN_EN to implement second/margin/low_conf;
// when undefined those outputs are held at zero and their logic is removed.
module argmax_topk_scan #(
    parameter int N    = 8,
    parameter int W    = 16,
    parameter int Y_AW = 3,
    parameter int LW   = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic [1:0]           mode,
    input  logic [W:0]           thresh,
    output logic                 y_cs,
    output logic                 y_we,
    output logic [Y_AW-1:0]      y_addr,
    output logic [W-1:0]         y_din,
    input  logic [W-1:0]         y_dout,
    output logic                 busy,
    output logic                 done,
    output logic                 empty,
    output logic [$clog2(N)-1:0] index,
    output logic [W-1:0]         best,
    output logic [W-1:0]         second,
    output logic [W:0]           margin,
    output logic                 low_conf
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;
    typedef enum logic [1:0] {M_SMAX = 2'b00, M_SMIN = 2'b01, M_UMAX = 2'b10} cmode_t;

    // True when a is strictly better than b under the latched compare mode
    function automatic logic better(input cmode_t m, input logic [W-1:0] a, input logic [W-1:0] b);
        case (m)
            M_SMIN:  return $signed(a) < $signed(b);
            M_UMAX:  return a > b;
            default: return $signed(a) > $signed(b);
        endcase
    endfunction

    state_t          state_q, state_d;
    cmode_t          mode_q, mode_d;
    logic            y_cs_q, y_cs_d;
    logic [Y_AW-1:0] y_addr_q, y_addr_d;
    logic [Y_AW-1:0] last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            empty_q, empty_d;

    logic            vld_q, vld_d;
    logic [IW-1:0]   k_q, k_d;
    logic [W-1:0]    wbest_q, wbest_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [IW-1:0]   index_q, index_d;
    logic [W-1:0]    best_q, best_d;

    logic [LW-1:0]   len_c;
    logic            accept;
    logic            fin;

    assign len_c  = (len > LW'(N)) ? LW'(N) : len;
    assign accept = (state_q == S_IDLE) && start;
    assign fin    = (state_q == S_FIN);

`ifdef ARGMAX_MARGIN_EN
    function automatic logic [W-1:0] mode_identity(input cmode_t m);
        case (m)
            M_SMIN:  return {1'b0, {(W-1){1'b1}}};
            M_UMAX:  return '0;
            default: return {1'b1, {(W-1){1'b0}}};
        endcase
    endfunction

    logic            one_q, one_d;
    logic [W-1:0]    wsec_q, wsec_d;
    logic [W-1:0]    second_q, second_d;
    logic [W:0]      margin_q, margin_d;
    logic            low_conf_q, low_conf_d;
    logic [W:0]      ext_b, ext_s, mg;

    // Margin in W+1 bits with mode-correct extension; single-element scans saturate
    always_comb begin
        ext_b = (mode_q == M_UMAX) ? {1'b0, wbest_q} : {wbest_q[W-1], wbest_q};
        ext_s = (mode_q == M_UMAX) ? {1'b0, wsec_q}  : {wsec_q[W-1], wsec_q};
        if (one_q)
            mg = '1;
        else if (mode_q == M_SMIN)
            mg = ext_s - ext_b;
        else
            mg = ext_b - ext_s;
    end

    assign second   = second_q;
    assign margin   = margin_q;
    assign low_conf = low_conf_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;

    assign second   = '0;
    assign margin   = '0;
    assign low_conf = 1'b0;
`endif

    // Control FSM: address issue, drain of the read pipeline, done pulse
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        y_cs_d   = y_cs_q;
        y_addr_d = y_addr_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        empty_d  = empty_q;
`ifdef ARGMAX_MARGIN_EN
        one_d    = one_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    mode_d = (mode == 2'b11) ? M_SMAX : cmode_t'(mode);
`ifdef ARGMAX_MARGIN_EN
                    one_d  = (len_c == LW'(1));
`endif
                    if (len_c == '0) begin
                        empty_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        empty_d  = 1'b0;
                        y_cs_d   = 1'b1;
                        y_addr_d = '0;
                        last_d   = Y_AW'(len_c - LW'(1));
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (y_addr_q == last_q) begin
                    y_cs_d  = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    y_addr_d = y_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (vld_q)
                    state_d = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Compare pipeline: running winner/runner-up, results latched on the done edge
    always_comb begin
        vld_d   = y_cs_q;
        k_d     = k_q;
        wbest_d = wbest_q;
        widx_d  = widx_q;
        index_d = index_q;
        best_d  = best_q;
`ifdef ARGMAX_MARGIN_EN
        wsec_d     = wsec_q;
        second_d   = second_q;
        margin_d   = margin_q;
        low_conf_d = low_conf_q;
`endif
        if (accept) begin
            k_d     = '0;
            wbest_d = '0;
            widx_d  = '0;
`ifdef ARGMAX_MARGIN_EN
            wsec_d  = '0;
`endif
        end else if (vld_q) begin
            if (k_q == '0) begin
                wbest_d = y_dout;
                widx_d  = '0;
`ifdef ARGMAX_MARGIN_EN
                wsec_d  = mode_identity(mode_q);
`endif
            end else if (better(mode_q, y_dout, wbest_q)) begin
`ifdef ARGMAX_MARGIN_EN
                wsec_d  = wbest_q;
`endif
                wbest_d = y_dout;
                widx_d  = k_q;
            end
`ifdef ARGMAX_MARGIN_EN
            else if (!better(mode_q, wsec_q, y_dout)) begin
                wsec_d = y_dout;
            end
`endif
            k_d = k_q + 1'b1;
        end
        if (fin) begin
            index_d = widx_q;
            best_d  = wbest_q;
`ifdef ARGMAX_MARGIN_EN
            second_d   = wsec_q;
            margin_d   = mg;
            low_conf_d = (mg < thresh);
`endif
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_SMAX;
            y_cs_q   <= 1'b0;
            y_addr_q <= '0;
            last_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            empty_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            one_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            y_cs_q   <= y_cs_d;
            y_addr_q <= y_addr_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            empty_q  <= empty_d;
`ifdef ARGMAX_MARGIN_EN
            one_q    <= one_d;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            k_q     <= '0;
            wbest_q <= '0;
            widx_q  <= '0;
            index_q <= '0;
            best_q  <= '0;
`ifdef ARGMAX_MARGIN_EN
            wsec_q     <= '0;
            second_q   <= '0;
            margin_q   <= '0;
            low_conf_q <= 1'b0;
`endif
        end else begin
            vld_q   <= vld_d;
            k_q     <= k_d;
            wbest_q <= wbest_d;
            widx_q  <= widx_d;
            index_q <= index_d;
            best_q  <= best_d;
`ifdef ARGMAX_MARGIN_EN
            wsec_q     <= wsec_d;
            second_q   <= second_d;
            margin_q   <= margin_d;
            low_conf_q <= low_conf_d;
`endif
        end
    end

    assign y_cs   = y_cs_q;
    assign y_we   = 1'b0;
    assign y_addr = y_addr_q;
    assign y_din  = '0;
    assign busy   = busy_q;
    assign done   = done_q;
    assign empty  = empty_q;
    assign index  = index_q;
    assign best   = best_q;

endmodule

// File: tb/tb_argmax_topk_scan.sv
// Self-checking bench for argmax_topk_scan: fixed vectors, randomized scans
// against a sort-style reference model, mid-scan reset and back-to-back starts.
module tb_argmax_topk_scan;

    localparam int N    = 8;
    localparam int W    = 16;
    localparam int Y_AW = 3;
    localparam int LW   = 4;
`ifdef ARGMAX_MARGIN_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic [1:0]      mode = '0;
    logic [W:0]      thresh = '0;
    logic            y_cs, y_we;
    logic [Y_AW-1:0] y_addr;
    logic [W-1:0]    y_din, y_dout;
    logic            busy, done, empty, low_conf;
    logic [2:0]      index;
    logic [W-1:0]    best, second;
    logic [W:0]      margin;

    int checks = 0;
    int errors = 0;

    argmax_topk_scan #(.N(N), .W(W), .Y_AW(Y_AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .thresh(thresh),
        .y_cs(y_cs), .y_we(y_we), .y_addr(y_addr), .y_din(y_din), .y_dout(y_dout),
        .busy(busy), .done(done), .empty(empty), .index(index), .best(best),
        .second(second), .margin(margin), .low_conf(low_conf)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model
    logic [W-1:0] mem [N];
    logic [W-1:0] rdata = '0;
    always @(posedge clk) if (y_cs) rdata <= mem[y_addr];
    assign y_dout = rdata;

    int cs_total = 0;
    bit we_bad = 1'b0;
    always @(posedge clk) begin
        if (y_cs) cs_total <= cs_total + 1;
        if (y_we !== 1'b0 || y_din !== '0) we_bad <= 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load_a();
        mem[0] = 16'h0003; mem[1] = 16'hFFFB; mem[2] = 16'h000C; mem[3] = 16'h0007;
        mem[4] = 16'h000C; mem[5] = 16'hFFFF; mem[6] = 16'h0000; mem[7] = 16'h0002;
    endtask

    task automatic load_b();
        mem[0] = 16'hFFFF; mem[1] = 16'h0001;
        for (int i = 2; i < N; i++) mem[i] = 16'h1234;
    endtask

    function automatic longint key(input logic [W-1:0] v, input logic [1:0] m);
        if (m == 2'b01) return -longint'($signed(v));
        if (m == 2'b10) return longint'(v);
        return longint'($signed(v));
    endfunction

    // Reference: winner = first element with the best key; runner-up = best key among the rest
    task automatic model(input int l, input logic [1:0] m, input logic [W:0] th,
                         output int e_idx, output logic [W-1:0] e_best, output logic [W-1:0] e_sec,
                         output logic [W:0] e_mg, output logic e_low, output logic e_empty);
        int n;
        int si;
        n = (l > N) ? N : l;
        e_idx = 0; e_best = '0; e_sec = '0; e_mg = '0; e_empty = (n == 0);
        if (n > 0) begin
            for (int i = 1; i < n; i++)
                if (key(mem[i], m) > key(mem[e_idx], m)) e_idx = i;
            e_best = mem[e_idx];
            if (n == 1) begin
                e_sec = (m == 2'b01) ? 16'h7FFF : (m == 2'b10) ? 16'h0000 : 16'h8000;
                e_mg  = '1;
            end else begin
                si = -1;
                for (int i = 0; i < n; i++)
                    if (i != e_idx && (si < 0 || key(mem[i], m) > key(mem[si], m))) si = i;
                e_sec = mem[si];
                e_mg  = 17'(key(e_best, m) - key(e_sec, m));
            end
        end
        e_low = (e_mg < th);
        if (!MEN) begin e_sec = '0; e_mg = '0; e_low = 1'b0; end
    endtask

    // Drives one scan starting at the current negedge; returns edges from accept to done
    task automatic do_scan(input int l, input logic [1:0] m, input logic [W:0] th,
                           output int cyc, output logic b0, output logic bd);
        len = LW'(l); mode = m; thresh = th; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); b0 = busy; cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        bd = busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (y_cs !== 1'b0) begin errors++; $display("FAIL reset_y_cs got %0b want 0", y_cs); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%0b done=%0b empty=%0b want 0", busy, done, empty); end
        checks++; if (index !== '0 || best !== '0 || second !== '0) begin errors++; $display("FAIL reset_results got idx=%0d best=%h sec=%h want 0", index, best, second); end
        checks++; if (margin !== '0 || low_conf !== 1'b0) begin errors++; $display("FAIL reset_margin got mg=%h low=%0b want 0", margin, low_conf); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit         ramb;
        logic [1:0] mode;
        int         len;
        logic [W:0] th;
        int         idx;
        logic [W-1:0] best;
        logic [W-1:0] sec;
        logic [W:0] mg;
        logic       low;
        logic       emp;
    } vec_t;

    task automatic test_plan();
        vec_t tbl [8];
        int cyc, exp_cyc, n, base;
        logic b0, bd;
        logic [W-1:0] e_sec;
        logic [W:0] e_mg;
        logic e_low;
        tbl[0] = '{1'b0, 2'b00, 8, 17'd4, 2, 16'h000C, 16'h000C, 17'h00000, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 2'b01, 8, 17'd4, 1, 16'hFFFB, 16'hFFFF, 17'h00004, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'b10, 2, 17'd4, 0, 16'hFFFF, 16'h0001, 17'h0FFFE, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 2'b00, 2, 17'd4, 1, 16'h0001, 16'hFFFF, 17'h00002, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 2'b00, 0, 17'd4, 0, 16'h0000, 16'h0000, 17'h00000, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 2'b00, 1, 17'd4, 0, 16'h0003, 16'h8000, 17'h1FFFF, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'b00, 9, 17'd4, 2, 16'h000C, 16'h000C, 17'h00000, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 2'b11, 2, 17'd4, 1, 16'h0001, 16'hFFFF, 17'h00002, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].ramb) load_b(); else load_a();
            n = (tbl[i].len > N) ? N : tbl[i].len;
            exp_cyc = (n == 0) ? 1 : n + 2;
            e_sec = MEN ? tbl[i].sec : '0;
            e_mg  = MEN ? tbl[i].mg  : '0;
            e_low = MEN ? tbl[i].low : 1'b0;
            base = cs_total;
            do_scan(tbl[i].len, tbl[i].mode, tbl[i].th, cyc, b0, bd);
            checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL plan%0d_latency got %0d want %0d", i, cyc, exp_cyc); end
            checks++; if (b0 !== 1'b1 || bd !== 1'b0) begin errors++; $display("FAIL plan%0d_busy got start=%0b done=%0b want 1/0", i, b0, bd); end
            checks++; if (cs_total - base !== n) begin errors++; $display("FAIL plan%0d_reads got %0d want %0d", i, cs_total - base, n); end
            checks++; if (index !== 3'(tbl[i].idx)) begin errors++; $display("FAIL plan%0d_index got %0d want %0d", i, index, tbl[i].idx); end
            checks++; if (best !== tbl[i].best) begin errors++; $display("FAIL plan%0d_best got %h want %h", i, best, tbl[i].best); end
            checks++; if (second !== e_sec) begin errors++; $display("FAIL plan%0d_second got %h want %h", i, second, e_sec); end
            checks++; if (margin !== e_mg) begin errors++; $display("FAIL plan%0d_margin got %h want %h", i, margin, e_mg); end
            checks++; if (low_conf !== e_low || empty !== tbl[i].emp) begin errors++; $display("FAIL plan%0d_flags got low=%0b empty=%0b want %0b/%0b", i, low_conf, empty, e_low, tbl[i].emp); end
        end
    endtask

    task automatic test_random();
        int cyc, l, n, e_idx;
        logic [1:0] m;
        logic [W:0] th;
        logic b0, bd, e_low, e_emp;
        logic [W-1:0] e_best, e_sec;
        logic [W:0] e_mg;
        logic [W-1:0] ext [5];
        ext[0] = 16'h8000; ext[1] = 16'h7FFF; ext[2] = 16'hFFFF; ext[3] = 16'h0000; ext[4] = 16'h0001;
        for (int it = 0; it < 30; it++) begin
            for (int j = 0; j < N; j++) begin
                case (it % 3)
                    0:       mem[j] = 16'($urandom);
                    1:       mem[j] = 16'($urandom_range(0, 4)) - 16'd2;
                    default: mem[j] = ext[$urandom_range(0, 4)];
                endcase
            end
            l  = (it == 0) ? 0 : (it == 1) ? 1 : (it == 2) ? 9 : int'($urandom_range(0, 10));
            m  = 2'($urandom_range(0, 3));
            th = (it % 2 == 0) ? 17'($urandom_range(0, 8)) : 17'($urandom);
            model(l, m, th, e_idx, e_best, e_sec, e_mg, e_low, e_emp);
            n = (l > N) ? N : l;
            do_scan(l, m, th, cyc, b0, bd);
            checks++; if (cyc !== ((n == 0) ? 1 : n + 2)) begin errors++; $display("FAIL rand%0d_latency got %0d len=%0d", it, cyc, l); end
            checks++; if (index !== 3'(e_idx) || best !== e_best) begin errors++; $display("FAIL rand%0d_winner got idx=%0d best=%h want idx=%0d best=%h", it, index, best, e_idx, e_best); end
            checks++; if (second !== e_sec || margin !== e_mg) begin errors++; $display("FAIL rand%0d_runnerup got sec=%h mg=%h want sec=%h mg=%h", it, second, margin, e_sec, e_mg); end
            checks++; if (low_conf !== e_low || empty !== e_emp) begin errors++; $display("FAIL rand%0d_flags got low=%0b empty=%0b want %0b/%0b", it, low_conf, empty, e_low, e_emp); end
        end
    endtask

    task automatic test_reset_midscan();
        int cyc;
        load_a();
        len = LW'(8); mode = 2'b00; thresh = 17'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || y_cs !== 1'b1) begin errors++; $display("FAIL midscan_active got busy=%0b cs=%0b want 1/1", busy, y_cs); end
        rst = 1'b1;
        #1;
        checks++; if (y_cs !== 1'b0 || y_addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midscan_rst_ctrl got cs=%0b addr=%0d busy=%0b done=%0b want 0", y_cs, y_addr, busy, done); end
        checks++; if (index !== '0 || best !== '0 || second !== '0 || margin !== '0 || low_conf !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL midscan_rst_results got idx=%0d best=%h sec=%h mg=%h low=%0b empty=%0b want 0", index, best, second, margin, low_conf, empty); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        // fresh scan, with a second start pulsed while it is busy
        len = LW'(8); mode = 2'b00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; cyc = 0;
        @(negedge clk);
        @(posedge clk); cyc++;
        @(negedge clk); len = LW'(1); mode = 2'b01; start = 1'b1;
        @(posedge clk); cyc++; #1 start = 1'b0;
        @(negedge clk);
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        checks++; if (cyc !== 10) begin errors++; $display("FAIL ignored_start_latency got %0d want 10", cyc); end
        checks++; if (index !== 3'd2 || best !== 16'h000C) begin errors++; $display("FAIL ignored_start_winner got idx=%0d best=%h want 2/000c", index, best); end
        checks++; if (second !== (MEN ? 16'h000C : 16'h0000) || low_conf !== MEN) begin errors++; $display("FAIL ignored_start_conf got sec=%h low=%0b", second, low_conf); end
    endtask

    task automatic test_back_to_back();
        int cyc, e_idx;
        logic b0, bd, e_low, e_emp;
        logic [W-1:0] e_best, e_sec;
        logic [W:0] e_mg;
        load_a();
        do_scan(3, 2'b10, 17'd100, cyc, b0, bd);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %0b want 1", done); end
        model(5, 2'b01, 17'd3, e_idx, e_best, e_sec, e_mg, e_low, e_emp);
        do_scan(5, 2'b01, 17'd3, cyc, b0, bd);
        checks++; if (cyc !== 7 || b0 !== 1'b1) begin errors++; $display("FAIL b2b_second_latency got %0d busy=%0b want 7/1", cyc, b0); end
        checks++; if (index !== 3'(e_idx) || best !== e_best || second !== e_sec || margin !== e_mg || low_conf !== e_low) begin errors++; $display("FAIL b2b_second_result got idx=%0d best=%h sec=%h mg=%h low=%0b want idx=%0d best=%h sec=%h mg=%h low=%0b", index, best, second, margin, low_conf, e_idx, e_best, e_sec, e_mg, e_low); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got done=%0b busy=%0b want 0/0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_reset_midscan();
        test_back_to_back();
        checks++; if (we_bad !== 1'b0) begin errors++; $display("FAIL ram_write_port got we/din nonzero want 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
